response_collector: RTL and testbench

Downstream consumer of the responder NoC at the requesting node. Pops 25-bit response packets from the NoC output FIFO, checks them against a 64-entry outstanding-request scoreboard, buffers accepted responses in a small FIFO and writes the reply data back to the local register file under a stall handshake. Misrouted and unexpected responses are dropped and flagged.

---
 rtl/resp_pkg.sv | 34 +++
 rtl/resp_fifo.sv | 63 ++++++
 rtl/response_collector.sv | 184 ++++++++++++++++++
 tb/tb_response_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_pkg.sv
// resp_pkg: shared widths, response packet field offsets and record types
// for the response collector.
//   DATA_W  reply data width
//   ID_W    query/register id width (scoreboard covers 2^ID_W ids)
//   RESP_W  response packet width: {data, reg_id, dest, valid}
//   DEPTH   internal response buffer entries (power of 2)
package resp_pkg;

   localparam int DATA_W   = 16;
   localparam int ID_W     = 6;
   localparam int RESP_W   = DATA_W + ID_W + 3;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = $clog2(DEPTH) + 1;

   // Field offsets inside a response packet
   localparam int VALID_B  = 0;
   localparam int DEST_LSB = 1;
   localparam int ID_LSB   = 3;
   localparam int DATA_LSB = 9;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   reg_id;
      logic [1:0]        dest;
      logic              valid;
   } resp_pkt_t;

   // What is kept per accepted response until it is written back
   typedef struct packed {
      logic [ID_W-1:0]   reg_id;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: DEPTH-entry synchronous FIFO holding accepted responses that
// wait for the writeback register.
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write one entry (caller guarantees not full)
//   pop               drop the head entry (caller guarantees not empty)
//   head              current head entry, valid while empty=0
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
module resp_fifo
   import resp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_entry_t        push_data,
   input  logic             pop,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH because DEPTH is a power of 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/response_collector.sv
// response_collector: pops response packets from the NoC output FIFO, checks
// them against the outstanding-request scoreboard, buffers accepted replies
// and writes them back to the local register file under a stall handshake.
//   clk, reset          clock, asynchronous active-high reset
//   id                  this node's port number
//   empty, dataIn       first-word-fall-through NoC FIFO head
//   read                pop the NoC FIFO this cycle
//   issue, issue_id     query issued by the local requestor
//   issue_ready         issue_id is not currently pending
//   wb_en/wb_id/wb_data registered writeback, held while wb_stall
//   wb_stall            register file cannot accept this cycle
//   pending_cnt         number of outstanding queries
//   err_misroute        pulse: popped packet addressed to another node
//   err_unexpected      pulse: popped packet for a non-pending id
//   err_id              reg_id of the last flagged packet
module response_collector
   import resp_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        id,
   input  logic              empty,
   input  logic [RESP_W-1:0] dataIn,
   output logic              read,
   input  logic              issue,
   input  logic [ID_W-1:0]   issue_id,
   output logic              issue_ready,
   output logic              wb_en,
   output logic [ID_W-1:0]   wb_id,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_stall,
   output logic [ID_W:0]     pending_cnt,
   output logic              err_misroute,
   output logic              err_unexpected,
   output logic [ID_W-1:0]   err_id
);

   localparam int NUM_IDS = 1 << ID_W;

   logic              pkt_valid;
   logic [1:0]        pkt_dest;
   logic [ID_W-1:0]   pkt_reg_id;
   logic [DATA_W-1:0] pkt_data;

   assign pkt_valid  = dataIn[VALID_B];
   assign pkt_dest   = dataIn[DEST_LSB +: 2];
   assign pkt_reg_id = dataIn[ID_LSB +: ID_W];
   assign pkt_data   = dataIn[DATA_LSB +: DATA_W];

   logic [NUM_IDS-1:0] pending_reg;
   logic [NUM_IDS-1:0] pending_next;
   logic [ID_W:0]      pending_cnt_reg;
   logic [ID_W:0]      pending_cnt_next;

   logic             consume;
   logic             misroute;
   logic             unexpected;
   logic             accept;
   logic             do_set;

   wb_entry_t        buf_head;
   wb_entry_t        buf_in;
   logic             buf_full;
   logic             buf_empty;
   logic [CNT_W-1:0] buf_count;
   logic             buf_push;
   logic             buf_pop;
   logic             wb_load;
   logic             bypass;

   logic              wb_en_reg;
   logic [ID_W-1:0]   wb_id_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic              err_misroute_reg;
   logic              err_unexpected_reg;
   logic [ID_W-1:0]   err_id_reg;

   // ---------------- classification of the popped packet ----------------
   assign read       = ~empty & (buf_count < CNT_W'(DEPTH));
   assign consume    = read & pkt_valid;
   assign misroute   = consume & (pkt_dest != id);
   assign unexpected = consume & (pkt_dest == id) & ~pending_reg[pkt_reg_id];
   assign accept     = consume & (pkt_dest == id) &  pending_reg[pkt_reg_id];

   // Readiness looks at the registered bitmap only, so a response clearing
   // the same id this cycle does not let the issue through until next cycle.
   assign issue_ready = ~pending_reg[issue_id];
   assign do_set      = issue & issue_ready;

   // ---------------- outstanding-request scoreboard ----------------
   // A set and a clear can never hit the same id in one cycle: a set needs
   // the bit to be 0, a clear needs it to be 1.
   generate
      for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_pending
         assign pending_next[gi] =
            (do_set && issue_id == ID_W'(gi))   ? 1'b1 :
            (accept && pkt_reg_id == ID_W'(gi)) ? 1'b0 :
                                                  pending_reg[gi];
      end
   endgenerate

   always_comb begin
      pending_cnt_next = pending_cnt_reg;
      if (do_set && !accept) begin
         pending_cnt_next = pending_cnt_reg + (ID_W+1)'(1);
      end else if (accept && !do_set) begin
         pending_cnt_next = pending_cnt_reg - (ID_W+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg     <= '0;
         pending_cnt_reg <= '0;
      end else begin
         pending_reg     <= pending_next;
         pending_cnt_reg <= pending_cnt_next;
      end
   end

   // ---------------- response buffer ----------------
   // The writeback register refills whenever it is empty or being drained.
   // If the buffer has nothing older, an accepted packet goes straight into
   // the register so it is written back the cycle after the pop.
   assign wb_load  = ~wb_en_reg | ~wb_stall;
   assign buf_pop  = wb_load & ~buf_empty;
   assign bypass   = wb_load & buf_empty & accept;
   assign buf_push = accept & ~bypass & ~buf_full;

   assign buf_in.reg_id = pkt_reg_id;
   assign buf_in.data   = pkt_data;

   resp_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .head      (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   // ---------------- writeback and error registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_en_reg          <= 1'b0;
         wb_id_reg          <= '0;
         wb_data_reg        <= '0;
         err_misroute_reg   <= 1'b0;
         err_unexpected_reg <= 1'b0;
         err_id_reg         <= '0;
      end else begin
         if (wb_load) begin
            if (!buf_empty) begin
               wb_en_reg   <= 1'b1;
               wb_id_reg   <= buf_head.reg_id;
               wb_data_reg <= buf_head.data;
            end else if (accept) begin
               wb_en_reg   <= 1'b1;
               wb_id_reg   <= pkt_reg_id;
               wb_data_reg <= pkt_data;
            end else begin
               wb_en_reg   <= 1'b0;
            end
         end
         err_misroute_reg   <= misroute;
         err_unexpected_reg <= unexpected;
         if (misroute || unexpected) begin
            err_id_reg <= pkt_reg_id;
         end
      end
   end

   assign wb_en          = wb_en_reg;
   assign wb_id          = wb_id_reg;
   assign wb_data        = wb_data_reg;
   assign pending_cnt    = pending_cnt_reg;
   assign err_misroute   = err_misroute_reg;
   assign err_unexpected = err_unexpected_reg;
   assign err_id         = err_id_reg;

endmodule

// File: tb/tb_response_collector.sv
// tb_response_collector: randomized bench for response_collector. A reference
// model tracks outstanding ids, the number of accepted-but-unwritten replies
// and their order; a separate monitor compares every presented writeback with
// the expected-reply queue.
module tb_response_collector;
   import resp_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        id;
   logic              empty;
   logic [RESP_W-1:0] dataIn;
   logic              read;
   logic              issue;
   logic [ID_W-1:0]   issue_id;
   logic              issue_ready;
   logic              wb_en;
   logic [ID_W-1:0]   wb_id;
   logic [DATA_W-1:0] wb_data;
   logic              wb_stall;
   logic [ID_W:0]     pending_cnt;
   logic              err_misroute;
   logic              err_unexpected;
   logic [ID_W-1:0]   err_id;

   always #5 clk = ~clk;

   response_collector dut (
      .clk            (clk),
      .reset          (reset),
      .id             (id),
      .empty          (empty),
      .dataIn         (dataIn),
      .read           (read),
      .issue          (issue),
      .issue_id       (issue_id),
      .issue_ready    (issue_ready),
      .wb_en          (wb_en),
      .wb_id          (wb_id),
      .wb_data        (wb_data),
      .wb_stall       (wb_stall),
      .pending_cnt    (pending_cnt),
      .err_misroute   (err_misroute),
      .err_unexpected (err_unexpected),
      .err_id         (err_id)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   bit              pend [1 << ID_W];
   int              outstanding;          // accepted replies not yet written back
   wb_entry_t       exp_q [$];            // expected writeback order
   logic            exp_mis;
   logic            exp_unx;
   logic [ID_W-1:0] exp_eid;

   function automatic int npend();
      int n = 0;
      foreach (pend[i]) n += int'(pend[i]);
      return n;
   endfunction

   // Reference model: checks combinational/registered outputs against the
   // model, then applies this cycle's transaction to the model.
   initial begin
      resp_pkt_t p;
      bit        ready;
      bit        rd;
      wb_entry_t e;
      outstanding = 0;
      exp_mis = 1'b0;
      exp_unx = 1'b0;
      exp_eid = '0;
      foreach (pend[i]) pend[i] = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            foreach (pend[i]) pend[i] = 1'b0;
            outstanding = 0;
            exp_q.delete();
            exp_mis = 1'b0;
            exp_unx = 1'b0;
            exp_eid = '0;
         end
         rd    = !empty && (outstanding <= DEPTH);
         ready = !pend[issue_id];
         chk("read",           32'(read),           32'(rd));
         chk("issue_ready",    32'(issue_ready),    32'(ready));
         chk("wb_en",          32'(wb_en),          32'(outstanding > 0));
         chk("pending_cnt",    32'(pending_cnt),    32'(npend()));
         chk("err_misroute",   32'(err_misroute),   32'(exp_mis));
         chk("err_unexpected", 32'(err_unexpected), 32'(exp_unx));
         chk("err_id",         32'(err_id),         32'(exp_eid));
         if (!reset) begin
            exp_mis = 1'b0;
            exp_unx = 1'b0;
            p = resp_pkt_t'(dataIn);
            if (outstanding > 0 && !wb_stall) outstanding--;
            if (rd && p.valid) begin
               if (p.dest != id) begin
                  exp_mis = 1'b1;
                  exp_eid = p.reg_id;
               end else if (!pend[p.reg_id]) begin
                  exp_unx = 1'b1;
                  exp_eid = p.reg_id;
               end else begin
                  pend[p.reg_id] = 1'b0;
                  e.reg_id = p.reg_id;
                  e.data   = p.data;
                  exp_q.push_back(e);
                  outstanding++;
               end
            end
            if (issue && ready) pend[issue_id] = 1'b1;
         end
      end
   end

   // Writeback monitor: whatever is presented must be the oldest expected
   // reply; it is retired when the register file accepts it.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && wb_en) begin
            if (exp_q.size() == 0) begin
               chk("wb_spurious", 32'(wb_en), 32'(0));
            end else begin
               chk("wb_id",   32'(wb_id),   32'(exp_q[0].reg_id));
               chk("wb_data", 32'(wb_data), 32'(exp_q[0].data));
               if (!wb_stall) begin
                  $display("writeback id=%0d data=%04h", wb_id, wb_data);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [RESP_W-1:0] mk(input logic [DATA_W-1:0] d, input logic [ID_W-1:0] rid,
                                            input logic [1:0] dst, input logic v);
      resp_pkt_t p;
      p.data   = d;
      p.reg_id = rid;
      p.dest   = dst;
      p.valid  = v;
      return p;
   endfunction

   task automatic drive(input logic e, input logic [RESP_W-1:0] d, input logic iss,
                        input logic [ID_W-1:0] iid, input logic st);
      empty    = e;
      dataIn   = d;
      issue    = iss;
      issue_id = iid;
      wb_stall = st;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ID_W-1:0] rand_id();
      if ($urandom_range(0, 8) == 8) return ID_W'(63);
      return ID_W'($urandom_range(0, 7));
   endfunction

   task automatic rand_phase(input int n, input int stall_pct);
      logic [1:0] dst;
      for (int k = 0; k < n; k++) begin
         dst = ($urandom_range(0, 7) == 0) ? 2'(id + 2'd1) : id;
         drive(($urandom_range(0, 3) == 0),
               mk(DATA_W'($urandom), rand_id(), dst, ($urandom_range(0, 9) != 0)),
               1'($urandom_range(0, 1)), rand_id(),
               ($urandom_range(0, 99) < stall_pct));
      end
   endtask

   initial begin
      reset    = 1'b1;
      id       = 2'($urandom_range(0, 3));
      empty    = 1'b1;
      dataIn   = '0;
      issue    = 1'b0;
      issue_id = '0;
      wb_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic accept, misroute, unexpected, duplicate issue
      drive(1'b1, '0, 1'b1, 6'd5, 1'b0);
      drive(1'b0, mk(16'hBEEF, 6'd5, id, 1'b1), 1'b1, 6'd7, 1'b0);
      drive(1'b0, mk(16'h1234, 6'd7, 2'(id + 2'd1), 1'b1), 1'b0, 6'd0, 1'b0);
      drive(1'b0, mk(16'h5555, 6'd9, id, 1'b1), 1'b1, 6'd3, 1'b0);
      drive(1'b1, '0, 1'b1, 6'd3, 1'b0);
      drive(1'b0, mk(16'hA5A5, 6'd3, id, 1'b1), 1'b1, 6'd3, 1'b0);
      drive(1'b1, '0, 1'b1, 6'd3, 1'b0);
      drive(1'b0, mk(16'h0707, 6'd7, id, 1'b1), 1'b0, 6'd0, 1'b0);
      drive(1'b0, mk(16'h0303, 6'd3, id, 1'b1), 1'b0, 6'd0, 1'b0);
      drive(1'b0, mk(16'h0000, 6'd3, id, 1'b0), 1'b0, 6'd0, 1'b0);

      // Fill the register plus buffer under stall, then release
      for (int i = 0; i < 6; i++) drive(1'b1, '0, 1'b1, ID_W'(i), 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b0, mk(DATA_W'(16'hC000 + i), ID_W'(i), id, 1'b1), 1'b0, 6'd0, 1'b1);
      repeat (4) drive(1'b0, mk(16'hC005, 6'd5, id, 1'b1), 1'b0, 6'd0, 1'b1);
      repeat (10) drive(1'b1, '0, 1'b0, 6'd0, 1'b0);

      // Random traffic
      rand_phase(600, 20);
      rand_phase(300, 90);
      rand_phase(40, 100);

      // Reset with replies buffered and a packet at the NoC head
      reset = 1'b1;
      drive(1'b0, mk(16'hDEAD, 6'd1, id, 1'b1), 1'b1, 6'd2, 1'b1);
      reset = 1'b0;

      rand_phase(300, 30);
      repeat (30) drive(1'b1, '0, 1'b0, 6'd0, 1'b0);
      chk("drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
